ram_handshake_controller: RTL and testbench
===========================================

Name: ram_handshake_controller

Overview:
- Byte-addressed, big-endian data/instruction memory with a MOV/MOC handshake sequencer.
- Sits directly upstream of the control unit and produces the MOC (memory operation complete) input it waits on.
- Consumes the control unit's MOV, RW and DL outputs, the MAR address and the MDR write data; returns read data to the MDR.
- Inserts a configurable number of wait states per access.

Parameters:
- ADDR_WIDTH, 8, byte-address width; memory depth is 2**ADDR_WIDTH bytes.
- WAIT_STATES, 1, idle cycles inserted before each transfer; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- MOV  input  1  memory operation request from the control unit.
- RW  input  1  1 = read, 0 = write.
- DL  input  2  data length: 00 byte, 01 halfword, 10 word, 11 treated as word.
- address  input  ADDR_WIDTH  byte address from MAR.
- data_in  input  32  write data from MDR, right-justified.
- data_out  output  32  read data to MDR, zero-extended, right-justified.
- MOC  output  1  operation complete; registered.
- busy  output  1  high in every state except IDLE.
- align_err  output  1  misaligned-access flag (see Optional Feature).

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; MOC = 0, busy = 0, data_out = 0, align_err = 0, wait counter = 0.
  - Memory contents are not cleared.
  - A write not yet at its XFER edge is aborted, and memory is unchanged.
- FSM states: IDLE, WAIT, XFER, DONE.
- IDLE:
  - On an edge with MOV = 1, latch RW, DL, address and data_in.
  - Go to WAIT with counter = WAIT_STATES, or go directly to XFER if WAIT_STATES = 0.
- WAIT:
  - Counter decrements each edge.
  - When counter = 1 at an edge, go to XFER.
  - Input changes are ignored; only latched values are used.
- XFER (exactly one cycle):
  - On its closing edge, the write is committed or data_out is loaded.
  - Then go to DONE.
- DONE:
  - MOC = 1.
  - Stay while MOV = 1. When MOV = 0 at an edge, go to IDLE and MOC falls on that edge.
- Latency: MOC rises on edge WAIT_STATES + 2 after the edge that sampled MOV in IDLE.
- MOV deasserted during WAIT/XFER: the transaction still completes, MOC is high for exactly one cycle, then IDLE.
- A new request is accepted only from IDLE, which requires MOV low for at least one edge after DONE.
- Addressing:
  - Halfword accesses force address bit 0 to 0; word accesses force bits [1:0] to 00.
  - Address arithmetic wraps modulo 2**ADDR_WIDTH.
- Big-endian read (base a):
  - Word: data_out = {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
  - Halfword: data_out = {16'b0, mem[a], mem[a+1]}.
  - Byte: data_out = {24'b0, mem[a]}.
- Big-endian write:
  - Byte writes data_in[7:0] to mem[a].
  - Halfword writes data_in[15:8] to mem[a] and data_in[7:0] to mem[a+1].
  - Word writes data_in[31:24] through data_in[7:0] to mem[a] through mem[a+3].
  - Untouched bytes are preserved.
- data_out holds its last read value across writes and idle periods.
- busy = (state != IDLE).

Optional Feature:
- Macro: RAM_ALIGN_CHECK_EN.
- Defined:
  - Misalignment is checked on the latched request: a halfword with address[0] = 1, or a word/DL = 11 with address[1:0] != 00.
  - On misalignment, XFER performs no write and does not change data_out.
  - align_err = 1 together with MOC in DONE; it clears on the transition back to IDLE.
  - Handshake timing is unchanged.
- Not defined:
  - The address is silently force-aligned as described in Behaviour.
  - align_err is tied to 0.

Test Plan:
- WAIT_STATES = 1, word write 0xDEADBEEF to 0x10, then word read 0x10:
  - data_out = 0xDEADBEEF.
  - mem[0x10..0x13] = DE, AD, BE, EF.
  - MOC rises 3 edges after MOV is sampled.
- Byte write 0xAB to 0x11 over that word, then word read 0x10:
  - data_out = 0xDEABBEEF.
  - Halfword read 0x12 returns 0x0000BEEF; byte read 0x13 returns 0x000000EF.
- Hold MOV high for 5 cycles after MOC:
  - MOC stays 1 and no second access occurs.
  - Drop MOV: MOC falls on the next edge and busy = 0.
  - WAIT_STATES = 0 variant: MOC rises 2 edges after MOV.
- Assert reset low mid-WAIT of a word write of 0x12345678 to 0x20:
  - MOC, busy and data_out go to 0 immediately.
  - mem[0x20..0x23] is unchanged.
  - After reset releases, a new request completes normally.
- Word read at 0x22 (misaligned):
  - Without RAM_ALIGN_CHECK_EN: returns the word at 0x20, align_err = 0.
  - With the macro: data_out is unchanged, align_err = 1 with MOC, and a write to 0x22 leaves memory unchanged.
- Word write 0x01020304 to 0xFC with ADDR_WIDTH = 8, then word read 0xFC:
  - Read returns 0x01020304, and no access touches 0x00.

Source files
------------

// File: rtl/ram_handshake_controller.sv
// Byte-addressed big-endian RAM with a MOV/MOC handshake and WAIT_STATES idle cycles per access.
// Optional misalignment detection when RAM_ALIGN_CHECK_EN is defined.
module ram_handshake_controller #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MOV,
  input  logic                  RW,
  input  logic [1:0]            DL,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  MOC,
  output logic                  busy,
  output logic                  align_err
);
  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t                state, state_nx;
  logic [3:0]            cnt;
  logic                  rw_q;
  logic [1:0]            dl_q;
  logic [ADDR_WIDTH-1:0] addr_q, a0, a1, a2, a3;
  logic [31:0]           wdata_q;
  logic                  moc_nx, mis;
  logic [7:0]            mem [0:(1<<ADDR_WIDTH)-1];

  always_comb begin
    a0 = addr_q;
    if (dl_q == 2'b01) a0[0] = 1'b0;
    else if (dl_q[1])  a0[1:0] = 2'b00;
    a1 = a0 + ADDR_WIDTH'(1);
    a2 = a0 + ADDR_WIDTH'(2);
    a3 = a0 + ADDR_WIDTH'(3);
  end

`ifdef RAM_ALIGN_CHECK_EN
  always_comb begin
    mis = 1'b0;
    if (dl_q == 2'b01) mis = addr_q[0];
    else if (dl_q[1])  mis = |addr_q[1:0];
  end
`else
  assign mis = 1'b0;
`endif

  // DONE holds until MOC has been high for a cycle, so a MOV dropped early still yields one MOC pulse.
  always_comb begin
    state_nx = state;
    moc_nx   = 1'b0;
    case (state)
      IDLE: if (MOV) state_nx = (WS == 4'd0) ? XFER : WAIT;
      WAIT: if (cnt <= 4'd1) state_nx = XFER;
      XFER: state_nx = DONE;
      DONE: begin
        if (MOC && !MOV) state_nx = IDLE;
        else             moc_nx   = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      rw_q     <= 1'b0;
      dl_q     <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      MOC      <= 1'b0;
      data_out <= 32'd0;
    end else begin
      state <= state_nx;
      MOC   <= moc_nx;
      if (state == IDLE && MOV) begin
        cnt     <= WS;
        rw_q    <= RW;
        dl_q    <= DL;
        addr_q  <= address;
        wdata_q <= data_in;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == XFER && rw_q && !mis) begin
        case (dl_q)
          2'b00:   data_out <= {24'd0, mem[a0]};
          2'b01:   data_out <= {16'd0, mem[a0], mem[a1]};
          default: data_out <= {mem[a0], mem[a1], mem[a2], mem[a3]};
        endcase
      end
    end
  end

`ifdef RAM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) align_err <= 1'b0;
    else        align_err <= moc_nx & mis;
  end
`else
  assign align_err = 1'b0;
`endif

  // Memory has no reset; a reset before XFER leaves state IDLE so no write lands.
  always_ff @(posedge clk) begin
    if (state == XFER && !rw_q && !mis) begin
      case (dl_q)
        2'b00: mem[a0] <= wdata_q[7:0];
        2'b01: begin
          mem[a0] <= wdata_q[15:8];
          mem[a1] <= wdata_q[7:0];
        end
        default: begin
          mem[a0] <= wdata_q[31:24];
          mem[a1] <= wdata_q[23:16];
          mem[a2] <= wdata_q[15:8];
          mem[a3] <= wdata_q[7:0];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_handshake_controller.sv
// Scoreboard bench: requests push expected data_out/align_err; a monitor checks them on each MOC rise.
module tb_ram_handshake_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mov = 1'b0, rw = 1'b0;
  logic [1:0]  dl = 2'b00;
  logic [7:0]  address = 8'h00;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        moc, busy, align_err;

  logic        mov0 = 1'b0, rw0 = 1'b0;
  logic [1:0]  dl0 = 2'b00;
  logic [7:0]  address0 = 8'h00;
  logic [31:0] data_in0 = 32'd0;
  logic [31:0] data_out0;
  logic        moc0, busy0, align_err0;

  int tests = 0;
  int fails = 0;

  typedef struct {logic [31:0] d; logic ae;} exp_t;
  exp_t exp_q[$];

  ram_handshake_controller #(.ADDR_WIDTH(8), .WAIT_STATES(1)) dut (
    .clk(clk), .reset(reset), .MOV(mov), .RW(rw), .DL(dl), .address(address),
    .data_in(data_in), .data_out(data_out), .MOC(moc), .busy(busy), .align_err(align_err));

  ram_handshake_controller #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .MOV(mov0), .RW(rw0), .DL(dl0), .address(address0),
    .data_in(data_in0), .data_out(data_out0), .MOC(moc0), .busy(busy0), .align_err(align_err0));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per MOC rising edge.
  logic moc_d = 1'b0;
  always @(negedge clk) begin
    if (moc && !moc_d) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_moc: got MOC rise expected none");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data_out", data_out, e.d);
        chk("align_err", {31'd0, align_err}, {31'd0, e.ae});
      end
    end
    moc_d <= moc;
  end

  task automatic req(input bit r, input logic [1:0] l, input logic [7:0] a,
                     input logic [31:0] wd, input logic [31:0] ed, input bit ea,
                     input int hold, input bit short_mov);
    int n;
    bit ok;
    @(negedge clk);
    mov = 1'b1; rw = r; dl = l; address = a; data_in = wd;
    exp_q.push_back('{ed, ea});
    @(posedge clk);
    #1;
    rw = ~r; dl = 2'b11; address = 8'h55; data_in = 32'hFFFF_FFFF;
    if (short_mov) begin
      @(negedge clk);
      mov = 1'b0;
    end
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (moc) break;
    end
    chk("latency_ws1", n, 3);
    if (hold > 0) begin
      ok = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1;
        ok &= moc & busy;
      end
      chk("moc_hold", {31'd0, ok}, 32'd1);
    end
    if (!short_mov) begin
      @(negedge clk);
      mov = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("moc_fall", {31'd0, moc}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic req0(input bit r, input logic [1:0] l, input logic [7:0] a,
                      input logic [31:0] wd, input logic [31:0] ed);
    int n;
    @(negedge clk);
    mov0 = 1'b1; rw0 = r; dl0 = l; address0 = a; data_in0 = wd;
    @(posedge clk);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (moc0) break;
    end
    chk("latency_ws0", n, 2);
    chk("data_out_ws0", data_out0, ed);
    @(negedge clk);
    mov0 = 1'b0;
    @(posedge clk);
    #1;
    chk("moc_fall_ws0", {31'd0, moc0}, 32'd0);
  endtask

  logic [31:0] mis_rd, mis_after;
  logic        mis_ae;

  initial begin
`ifdef RAM_ALIGN_CHECK_EN
    mis_rd = 32'h0000_00DE; mis_ae = 1'b1; mis_after = 32'hCAFE_F00D;
`else
    mis_rd = 32'hCAFE_F00D; mis_ae = 1'b0; mis_after = 32'h5566_7788;
`endif
    #1 reset = 1'b0;
    #2;
    chk("rst_moc", {31'd0, moc}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_align_err", {31'd0, align_err}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    req(1'b0, 2'b10, 8'h10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0, 1'b0);
    req(1'b1, 2'b10, 8'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    req(1'b0, 2'b00, 8'h11, 32'h0000_00AB, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    req(1'b1, 2'b10, 8'h10, 32'h0,         32'hDEAB_BEEF, 1'b0, 0, 1'b0);
    req(1'b1, 2'b01, 8'h12, 32'h0,         32'h0000_BEEF, 1'b0, 0, 1'b0);
    req(1'b1, 2'b00, 8'h13, 32'h0,         32'h0000_00EF, 1'b0, 0, 1'b0);
    req(1'b0, 2'b01, 8'h12, 32'h0000_1234, 32'h0000_00EF, 1'b0, 0, 1'b0);
    req(1'b1, 2'b10, 8'h10, 32'h0,         32'hDEAB_1234, 1'b0, 0, 1'b0);
    req(1'b1, 2'b00, 8'h10, 32'h0,         32'h0000_00DE, 1'b0, 5, 1'b0);
    req(1'b1, 2'b01, 8'h12, 32'h0,         32'h0000_1234, 1'b0, 0, 1'b1);
    req(1'b0, 2'b10, 8'h20, 32'hCAFE_F00D, 32'h0000_1234, 1'b0, 0, 1'b0);
    req(1'b1, 2'b00, 8'h10, 32'h0,         32'h0000_00DE, 1'b0, 0, 1'b0);

    // Abort a word write while it sits in WAIT.
    @(negedge clk);
    mov = 1'b1; rw = 1'b0; dl = 2'b10; address = 8'h20; data_in = 32'h1234_5678;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_moc", {31'd0, moc}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_data_out", data_out, 32'd0);
    @(negedge clk);
    mov = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    req(1'b1, 2'b10, 8'h20, 32'h0,         32'hCAFE_F00D, 1'b0, 0, 1'b0);

    req(1'b1, 2'b00, 8'h10, 32'h0,         32'h0000_00DE, 1'b0, 0, 1'b0);
    req(1'b1, 2'b10, 8'h22, 32'h0,         mis_rd,        mis_ae, 0, 1'b0);
    req(1'b0, 2'b10, 8'h22, 32'h5566_7788, mis_rd,        mis_ae, 0, 1'b0);
    req(1'b1, 2'b10, 8'h20, 32'h0,         mis_after,     1'b0, 0, 1'b0);

    req(1'b0, 2'b00, 8'h00, 32'h0000_0077, mis_after,     1'b0, 0, 1'b0);
    req(1'b0, 2'b10, 8'hFC, 32'h0102_0304, mis_after,     1'b0, 0, 1'b0);
    req(1'b1, 2'b10, 8'hFC, 32'h0,         32'h0102_0304, 1'b0, 0, 1'b0);
    req(1'b1, 2'b00, 8'h00, 32'h0,         32'h0000_0077, 1'b0, 0, 1'b0);
    req(1'b1, 2'b01, 8'hFE, 32'h0,         32'h0000_0304, 1'b0, 0, 1'b0);

    req0(1'b0, 2'b10, 8'h40, 32'hA1B2_C3D4, 32'h0000_0000);
    req0(1'b1, 2'b10, 8'h40, 32'h0,         32'hA1B2_C3D4);
    req0(1'b1, 2'b01, 8'h42, 32'h0,         32'h0000_C3D4);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
